// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and
// a constant-function log2 used to size/check the hold counter.
package pulse_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD,
        GAP  = ST_GAP
    } state_t;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_cnt.sv
// Loadable down-counter for the pulse stretcher hold/gap timing.
// Load wins over decrement; it saturates at zero and never wraps.
module pulse_cnt
    import pulse_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // count register: reload on request, otherwise step down to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse -> level converter with minimum hold and recovery gap.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: pulses in HOLD reload.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic level_out,
    output logic busy,
    output logic done,
    output logic dropped
);

    localparam int NEED_W = clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_M1);

    generate
        if (CNT_W < NEED_W) begin : g_cnt_w_chk
            $error("pulse_stretcher: CNT_W too small");
        end
    endgenerate

    state_t           state;
    state_t           state_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             dec;
    logic             zero;
    logic             done_d;
    logic             drop_d;

    pulse_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_val(load_val),
        .dec     (dec),
        .zero    (zero)
    );

    // next state, counter control and strobe decode
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        load_val = HOLD_LD;
        dec      = 1'b0;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (pulse_in) begin
                    state_d  = HOLD;
                    load     = 1'b1;
                    load_val = HOLD_LD;
                end
            end
            (state == HOLD): begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (pulse_in) begin
                    load     = 1'b1;
                    load_val = HOLD_LD;
                end else if (zero) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        load     = 1'b1;
                        load_val = GAP_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dec = 1'b1;
                end
`else
                drop_d = pulse_in;
                if (zero) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        load     = 1'b1;
                        load_val = GAP_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dec = 1'b1;
                end
`endif
            end
            (state == GAP): begin
                drop_d = pulse_in;
                if (zero) begin
                    state_d = IDLE;
                end else begin
                    dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and registered outputs; reset beats every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            level_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state     <= state_d;
            level_out <= (state_d == HOLD);
            busy      <= (state_d != IDLE);
            done      <= done_d;
            dropped   <= drop_d;
        end
    end

endmodule
